// File: rtl/count_ud.sv
// count_ud: parametrised up/down counter with load, terminal-count, zero and
// sticky overflow flags. Used for factorial datapath iteration counts and
// general loop control.
//
// Parameters:
//   WIDTH  counter width in bits (2..32)
//   MAX    highest legal count value, 1 <= MAX <= 2**WIDTH-1
//   STEP   amount added/subtracted per enabled cycle, 1 <= STEP <= MAX
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   ld_count  in   load D (clamped to MAX); beats EN, clears ovf
//   EN        in   count enable
//   up        in   direction, 1 = up, 0 = down
//   D         in   load value
//   Q         out  registered count, always in 0..MAX
//   zero      out  Q == 0 (combinational)
//   tc        out  next enabled step in direction 'up' would cross the range
//   ovf       out  sticky boundary-crossing flag, cleared by load or reset
//
// Build option: define COUNT_UD_SATURATE_EN to saturate at the range limits
// instead of wrapping around.

module count_ud #(
    parameter int unsigned     WIDTH = 4,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_count,
    input  logic             EN,
    input  logic             up,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             tc,
    output logic             ovf
);

    // One extra bit so MAX+1 and Q+STEP never truncate.
    localparam logic [WIDTH:0] MAX_W  = MAX[WIDTH:0];
    localparam logic [WIDTH:0] STEP_W = STEP[WIDTH:0];
    localparam logic [WIDTH:0] MOD_W  = MAX_W + 1'b1;
    localparam logic [WIDTH:0] UP_LIM = MAX_W - STEP_W;

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   q_ext, d_ext;
    logic             tc_up, tc_dn;

    assign q_ext = {1'b0, q_q};
    assign d_ext = {1'b0, D};
    assign tc_up = (q_ext > UP_LIM);
    assign tc_dn = (q_ext < STEP_W);

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (ld_count) begin
            q_d   = (d_ext > MAX_W) ? MAX_W[WIDTH-1:0] : D;
            ovf_d = 1'b0;
        end else if (EN) begin
            if (up) begin
                if (tc_up) begin
                    ovf_d = 1'b1;
`ifdef COUNT_UD_SATURATE_EN
                    q_d = MAX_W[WIDTH-1:0];
`else
                    q_d = WIDTH'(q_ext + STEP_W - MOD_W);
`endif
                end else begin
                    q_d = WIDTH'(q_ext + STEP_W);
                end
            end else begin
                if (tc_dn) begin
                    ovf_d = 1'b1;
`ifdef COUNT_UD_SATURATE_EN
                    q_d = '0;
`else
                    q_d = WIDTH'(q_ext + MOD_W - STEP_W);
`endif
                end else begin
                    q_d = WIDTH'(q_ext - STEP_W);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign ovf  = ovf_q;
    assign zero = (q_q == '0);
    assign tc   = up ? tc_up : tc_dn;

endmodule

// File: tb/tb_count_ud.sv
module tb_count_ud;

    localparam int MAX_A  = 15;
    localparam int STEP_A = 1;
    localparam int MAX_B  = 9;
    localparam int STEP_B = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ld = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] qa, qb;
    logic       za, ta, oa, zb, tcb, ob;

    int errors = 0;
    int checks = 0;
    int ma = 0, mb = 0;
    int va = 0, vb = 0;

    count_ud #(.WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .ld_count(ld), .EN(en), .up(up), .D(d),
        .Q(qa), .zero(za), .tc(ta), .ovf(oa)
    );

    count_ud #(.WIDTH(4), .MAX(9), .STEP(3)) dut_b (
        .clk(clk), .rst(rst), .ld_count(ld), .EN(en), .up(up), .D(d),
        .Q(qb), .zero(zb), .tc(tcb), .ovf(ob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: count lives on the integer line 0..mx; anything stepping past
    // either end is a boundary event that wraps modulo mx+1 or saturates.
    task automatic model_step(inout int m, inout int v, input int mx, input int st);
        int n;
        if (ld) begin
            m = (int'(d) > mx) ? mx : int'(d);
            v = 0;
        end else if (en) begin
            n = up ? m + st : m - st;
            if (n > mx || n < 0) begin
                v = 1;
`ifdef COUNT_UD_SATURATE_EN
                n = (n > mx) ? mx : 0;
`else
                n = (n > mx) ? n - (mx + 1) : n + (mx + 1);
`endif
            end
            m = n;
        end
    endtask

    function automatic int tc_exp(input int m, input int mx, input int st, input logic dir);
        return dir ? int'(m + st > mx) : int'(m - st < 0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".qa"},   32'(qa),  32'(ma));
        chk({tag, ".za"},   32'(za),  32'(ma == 0));
        chk({tag, ".oa"},   32'(oa),  32'(va));
        chk({tag, ".ta"},   32'(ta),  32'(tc_exp(ma, MAX_A, STEP_A, up)));
        chk({tag, ".qb"},   32'(qb),  32'(mb));
        chk({tag, ".zb"},   32'(zb),  32'(mb == 0));
        chk({tag, ".ob"},   32'(ob),  32'(vb));
        chk({tag, ".tb"},   32'(tcb), 32'(tc_exp(mb, MAX_B, STEP_B, up)));
    endtask

    // One clock: model follows the sampled inputs, outputs checked 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step(ma, va, MAX_A, STEP_A);
        model_step(mb, vb, MAX_B, STEP_B);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; va = 0; vb = 0;
    endtask

    initial begin
        // power-on reset, released before the first edge
        #1 rst = 1'b1;
        #1 model_reset();
        check_all("por");
        #1 rst = 1'b0;

        // load 7, then asynchronous reset in the middle of the cycle
        ld = 1'b1; d = 4'd7;
        cycle("ld7");
        ld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 model_reset();
        check_all("rst_mid");
        #1 rst = 1'b0;
        en = 1'b1; up = 1'b1;
        cycle("resume");

        // factorial countdown from 5
        en = 1'b0; ld = 1'b1; d = 4'd5;
        cycle("ld5");
        ld = 1'b0; en = 1'b1; up = 1'b0;
        for (int i = 0; i < 5; i++) cycle("cdown");
        chk("cdown_end", 32'(qa), 32'd0);

        // down wrap / saturate at 0
        cycle("dn_bound");
`ifdef COUNT_UD_SATURATE_EN
        chk("dn_bound_q", 32'(qa), 32'd0);
`else
        chk("dn_bound_q", 32'(qa), 32'd15);
`endif

        // modulus 10, step 3 from 0 on dut_b
        en = 1'b0; ld = 1'b1; d = 4'd0;
        cycle("ld0");
        ld = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) cycle("mod_up");
`ifdef COUNT_UD_SATURATE_EN
        chk("mod_up_q", 32'(qb), 32'd9);
`else
        chk("mod_up_q", 32'(qb), 32'd2);
`endif

        // load clamp with simultaneous enable
        ld = 1'b1; en = 1'b1; d = 4'd12;
        cycle("ld_clamp");
        chk("ld_clamp_q", 32'(qb), 32'd9);

        // hold with up toggling; tc must follow up within the cycle
        ld = 1'b0; en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            up = ~up;
            #1 check_all("hold_tc");
            cycle("hold");
        end

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            d  = 4'($urandom_range(0, 15));
            #1 check_all("rnd_tc");
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
